serial_adder: RTL and testbench

Bit-serial N-bit adder, the additive counterpart of the structural full-subtractor datapath.
- Loads two operands plus carry-in on a start pulse.
- Adds one bit per clock, LSB first, through a single structural full-adder cell and a carry flip-flop.
- Returns the sum and carry-out with a one-cycle done pulse.
- Serves as an area-minimal arithmetic unit next to the existing combinational add/subtract cells.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 21 ++
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and defaults for the bit-serial adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - structural one-bit full adder cell
module full_adder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic p;
    logic g;
    logic t;

    // Propagate/generate form, mirroring the full_subtractor gate style
    xor u_x0 (p, a, b);
    xor u_x1 (sum, p, cin);
    and u_a0 (g, a, b);
    and u_a1 (t, p, cin);
    or  u_o0 (cout, g, t);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one bit per clock, LSB first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    full_adder u_fa (
        .sum  (fa_s),
        .cout (fa_c),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result registers are written only on the final bit so they hold across new starts
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sr <= '0;
                    end
                end
                SHIFT: begin
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= {fa_s, sum_sr[WIDTH-1:1]};
                        cout <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int               n_vec;
    int               n_err;
    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one operation from a negedge; poke_at/rst_at name a busy cycle (1-based) or 0 for none
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                          input int poke_at, input int rst_at);
        logic [WIDTH:0] exp;
        int busy_cnt;
        int done_cnt;
        int cyc;
        bit aborted;
        exp = {1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tc};
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; cyc = 0; aborted = 0;
        while (cyc < 3 * WIDTH && done_cnt == 0 && !aborted) begin
            if (done) begin
                done_cnt++;
                chk("busy_in_done", 32'(busy), 32'(0));
            end else begin
                if (busy) begin
                    busy_cnt++;
                    if (busy_cnt == 1) begin
                        chk("hold_sum", 32'(sum), 32'(prev_sum));
                        chk("hold_cout", 32'(cout), 32'(prev_cout));
                    end
                    if (busy_cnt == poke_at) begin
                        a = 8'hAA; b = 8'h55; cin = ~tc; start = 1'b1;
                    end
                    if (busy_cnt == rst_at) rst = 1'b1;
                end
                @(negedge clk);
                start = 1'b0;
                if (rst) begin
                    rst = 1'b0;
                    aborted = 1;
                end
                cyc++;
            end
        end
        if (aborted) begin
            chk("abort_busy", 32'(busy), 32'(0));
            chk("abort_done", 32'(done), 32'(0));
            chk("abort_sum", 32'(sum), 32'(0));
            chk("abort_cout", 32'(cout), 32'(0));
            done_cnt = 0;
            for (int i = 0; i < WIDTH + 2; i++) begin
                if (done) done_cnt++;
                @(negedge clk);
            end
            chk("abort_no_done", 32'(done_cnt), 32'(0));
            prev_sum = '0;
            prev_cout = 1'b0;
        end else begin
            chk("done_seen", 32'(done_cnt), 32'(1));
            chk("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
            chk("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
            chk("cout", 32'(cout), 32'(exp[WIDTH]));
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'(0));
            chk("idle_busy", 32'(busy), 32'(0));
            prev_sum = exp[WIDTH-1:0];
            prev_cout = exp[WIDTH];
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        prev_sum = '0; prev_cout = 1'b0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        repeat (3) @(negedge clk);
        chk("idle_stays", 32'({busy, done}), 32'(0));

        run_op(8'h3C, 8'h05, 1'b0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 0);
        run_op(8'h10, 8'h20, 1'b0, 3, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 4);
        run_op(8'h7F, 8'h01, 1'b0, 0, 0);
        run_op(8'h01, 8'h01, 1'b1, 0, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH)) : 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
